// File: rtl/bp_dma_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// bp_dma_mem_responder_pkg
//   Shared types for the DMA memory responder:
//     - bp_dma_state_e : responder FSM states
//     - bp_dma_pkt_s   : DMA request packet {write_not_read, addr}
//   Optional feature macro: BP_DMA_MEM_DELAY_EN adds the e_delay state.
// ----------------------------------------------------------------------------
package bp_dma_mem_responder_pkg;

    // Byte-address width carried by a DMA packet (matches the daddr width).
    localparam int unsigned dma_addr_width_lp = 28;

`ifdef BP_DMA_MEM_DELAY_EN
    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_read  = 2'd1,
        e_write = 2'd2,
        e_delay = 2'd3
    } bp_dma_state_e;
`else
    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_read  = 2'd1,
        e_write = 2'd2
    } bp_dma_state_e;
`endif

    typedef struct packed {
        logic                         write_not_read;
        logic [dma_addr_width_lp-1:0] addr;
    } bp_dma_pkt_s;

endpackage

// File: rtl/bp_dma_mem_responder_store.sv
// ----------------------------------------------------------------------------
// bp_dma_mem_responder_store
//   Beat-wide backing store for the DMA responder.
//   One combinational read port, one synchronous write port; the whole array
//   is cleared by the asynchronous active-low reset.
//   Ports:
//     i_clk     : clock, rising edge
//     i_rst_n   : asynchronous active-low clear of every entry
//     i_we      : write enable
//     i_waddr   : write beat index
//     i_wdata   : write data
//     i_raddr   : read beat index
//     o_rdata   : read data (combinational)
// ----------------------------------------------------------------------------
module bp_dma_mem_responder_store
    import bp_dma_mem_responder_pkg::*;
#(
    parameter int width_p = 64,
    parameter int els_p   = 1024,
    localparam int addr_w_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_we,
    input  logic [addr_w_lp-1:0] i_waddr,
    input  logic [width_p-1:0]   i_wdata,
    input  logic [addr_w_lp-1:0] i_raddr,
    output logic [width_p-1:0]   o_rdata
);

    logic [width_p-1:0] r_mem [els_p];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < els_p; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bp_dma_mem_responder.sv
// ----------------------------------------------------------------------------
// bp_dma_mem_responder
//   Simulation-style DMA memory responder. Accepts a DMA packet, then streams
//   a block of block_beats_p beats out of (read) or into (write) a backing
//   store, one beat per handshake.
//   Optional feature macro: BP_DMA_MEM_DELAY_EN inserts delay_p idle cycles
//   (state e_delay) between packet acceptance and the first beat.
//   Ports:
//     clk_i                : clock, rising edge
//     reset_n_i            : asynchronous active-low reset
//     dma_pkt_i            : {write_not_read, byte address}
//     dma_pkt_v_i          : packet valid
//     dma_pkt_yumi_o       : packet consumed this cycle
//     dma_data_o           : read fill beat
//     dma_data_v_o         : read fill beat valid
//     dma_data_ready_and_i : receiver accepts the fill beat
//     dma_data_i           : writeback beat
//     dma_data_v_i         : writeback beat valid
//     dma_data_yumi_o      : writeback beat consumed this cycle
//   addr_width_p must equal the package packet address width (28).
// ----------------------------------------------------------------------------
module bp_dma_mem_responder
    import bp_dma_mem_responder_pkg::*;
#(
    parameter int addr_width_p  = 28,
    parameter int data_width_p  = 64,
    parameter int block_beats_p = 8,
    parameter int mem_els_p     = 1024,
    parameter int delay_p       = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [addr_width_p:0]   dma_pkt_i,
    input  logic                    dma_pkt_v_i,
    output logic                    dma_pkt_yumi_o,
    output logic [data_width_p-1:0] dma_data_o,
    output logic                    dma_data_v_o,
    input  logic                    dma_data_ready_and_i,
    input  logic [data_width_p-1:0] dma_data_i,
    input  logic                    dma_data_v_i,
    output logic                    dma_data_yumi_o
);

    localparam int byte_off_lp = $clog2(data_width_p / 8);
    localparam int cnt_w_lp    = (block_beats_p > 1) ? $clog2(block_beats_p) : 1;
    localparam int mem_aw_lp   = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;

    localparam logic [cnt_w_lp-1:0]  last_cnt_lp  = cnt_w_lp'(block_beats_p - 1);
    localparam logic [mem_aw_lp-1:0] blk_mask_lp  = mem_aw_lp'(block_beats_p - 1);

    bp_dma_state_e         r_state, w_state_next;
    bp_dma_pkt_s           r_pkt, w_pkt_next, w_pkt_in;
    logic [cnt_w_lp-1:0]   r_cnt, w_cnt_next;

`ifdef BP_DMA_MEM_DELAY_EN
    localparam int dly_w_lp = (delay_p > 0) ? $clog2(delay_p + 1) : 1;
    logic [dly_w_lp-1:0]   r_dly_cnt, w_dly_cnt_next;
`endif

    logic                  w_pkt_yumi;
    logic                  w_data_v;
    logic                  w_data_yumi;
    logic                  w_mem_we;
    logic [mem_aw_lp-1:0]  w_beat_idx;
    logic [mem_aw_lp-1:0]  w_beat_addr;
    logic [data_width_p-1:0] w_rdata;
    logic                  w_unused_addr;

    assign w_pkt_in = bp_dma_pkt_s'(dma_pkt_i);

    // Block-aligned beat index; the modulo mem_els_p wrap comes for free from
    // truncating to mem_aw_lp bits, both here and in the add below.
    assign w_beat_idx    = r_pkt.addr[byte_off_lp +: mem_aw_lp] & ~blk_mask_lp;
    assign w_beat_addr   = w_beat_idx + mem_aw_lp'(r_cnt);
    assign w_unused_addr = ^r_pkt.addr;

    // State, packet and beat counter registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= e_idle;
            r_pkt     <= '0;
            r_cnt     <= '0;
`ifdef BP_DMA_MEM_DELAY_EN
            r_dly_cnt <= '0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_pkt     <= w_pkt_next;
            r_cnt     <= w_cnt_next;
`ifdef BP_DMA_MEM_DELAY_EN
            r_dly_cnt <= w_dly_cnt_next;
`endif
        end
    end

    // Next-state and handshake logic
    always_comb begin
        w_state_next   = r_state;
        w_pkt_next     = r_pkt;
        w_cnt_next     = r_cnt;
        w_pkt_yumi     = 1'b0;
        w_data_v       = 1'b0;
        w_data_yumi    = 1'b0;
        w_mem_we       = 1'b0;
`ifdef BP_DMA_MEM_DELAY_EN
        w_dly_cnt_next = r_dly_cnt;
`endif

        case (r_state)
            e_idle: begin
                if (dma_pkt_v_i) begin
                    w_pkt_yumi = 1'b1;
                    w_pkt_next = w_pkt_in;
                    w_cnt_next = '0;
`ifdef BP_DMA_MEM_DELAY_EN
                    w_dly_cnt_next = dly_w_lp'(delay_p);
                    w_state_next   = e_delay;
`else
                    w_state_next = w_pkt_in.write_not_read ? e_write : e_read;
`endif
                end
            end

`ifdef BP_DMA_MEM_DELAY_EN
            e_delay: begin
                // Counter holds the remaining delay cycles including this one.
                if (r_dly_cnt <= dly_w_lp'(1)) begin
                    w_dly_cnt_next = '0;
                    w_state_next   = r_pkt.write_not_read ? e_write : e_read;
                end else begin
                    w_dly_cnt_next = r_dly_cnt - dly_w_lp'(1);
                end
            end
`endif

            e_read: begin
                w_data_v = 1'b1;
                if (dma_data_ready_and_i) begin
                    w_cnt_next = r_cnt + cnt_w_lp'(1);
                    if (r_cnt == last_cnt_lp) begin
                        w_state_next = e_idle;
                    end
                end
            end

            e_write: begin
                w_data_yumi = dma_data_v_i;
                w_mem_we    = dma_data_v_i;
                if (dma_data_v_i) begin
                    w_cnt_next = r_cnt + cnt_w_lp'(1);
                    if (r_cnt == last_cnt_lp) begin
                        w_state_next = e_idle;
                    end
                end
            end

            default: begin
                w_state_next = e_idle;
            end
        endcase
    end

    bp_dma_mem_responder_store #(
        .width_p (data_width_p),
        .els_p   (mem_els_p)
    ) u_store (
        .i_clk   (clk_i),
        .i_rst_n (reset_n_i),
        .i_we    (w_mem_we),
        .i_waddr (w_beat_addr),
        .i_wdata (dma_data_i),
        .i_raddr (w_beat_addr),
        .o_rdata (w_rdata)
    );

    // The idle-state yumi follows dma_pkt_v_i combinationally, so it must be
    // gated by reset explicitly; the other outputs are already 0 in e_idle.
    assign dma_pkt_yumi_o  = w_pkt_yumi & reset_n_i;
    assign dma_data_v_o    = w_data_v;
    assign dma_data_o      = w_data_v ? w_rdata : '0;
    assign dma_data_yumi_o = w_data_yumi;

endmodule

// File: doc/bp_dma_mem_responder.md
BP_DMA_MEM_RESPONDER -- requirements
Module: bp_dma_mem_responder

Interface
REQ-001 addr_width_p, 28, DMA byte-address width; matches the daddr width.
REQ-002 data_width_p, 64, DMA fill beat width in bits; power of two, at least 8.
REQ-003 block_beats_p, 8, beats per DMA block transfer; power of two.
REQ-004 mem_els_p, 1024, backing-store depth in beats; power of two, at least block_beats_p.
REQ-005 delay_p, 4, idle cycles before a transfer starts; used only when BP_DMA_MEM_DELAY_EN is defined.
REQ-006 clk_i  input  1  sole clock; rising edge.
REQ-007 reset_n_i  input  1  asynchronous, active-low reset.
REQ-008 dma_pkt_i  input  addr_width_p+1  bit[MSB] = write_not_read; bits[addr_width_p-1:0] = byte address.
REQ-009 dma_pkt_v_i  input  1  packet valid.
REQ-010 dma_pkt_yumi_o  output  1  packet consumed this cycle.
REQ-011 dma_data_o  output  data_width_p  read fill beat.
REQ-012 dma_data_v_o  output  1  fill beat valid.
REQ-013 dma_data_ready_and_i  input  1  receiver accepts the fill beat.
REQ-014 dma_data_i  input  data_width_p  writeback beat.
REQ-015 dma_data_v_i  input  1  writeback beat valid.
REQ-016 dma_data_yumi_o  output  1  writeback beat consumed this cycle.

Function
REQ-017 FSM states SHALL be e_idle, e_delay (macro only), e_read and e_write.
REQ-018 e_idle SHALL assert dma_pkt_yumi_o combinationally when dma_pkt_v_i is high, latch the packet and reset the beat counter to 0.
REQ-019 Next state after a yumi SHALL be e_delay when the macro is defined; otherwise e_read if write_not_read=0, else e_write.
REQ-020 Base beat index = (addr >> log2(data_width_p/8)) with the low log2(block_beats_p) bits cleared; beat address = (base + count) mod mem_els_p, wrapping silently.
REQ-021 e_read SHALL hold dma_data_v_o=1 with dma_data_o = mem[beat address], combinational read; a beat transfers when dma_data_ready_and_i=1.
REQ-022 e_read SHALL hold dma_data_o stable while stalled.
REQ-023 e_write SHALL set dma_data_yumi_o = dma_data_v_i, writing dma_data_i to mem[beat address] on the same clock edge.
REQ-024 The beat counter SHALL be log2(block_beats_p) bits, incrementing on each transferred beat; the transfer on count = block_beats_p-1 SHALL return the FSM to e_idle.
REQ-025 dma_pkt_yumi_o SHALL be 0 outside e_idle; a new packet is accepted no earlier than the cycle after the last beat (no overlap).
REQ-026 dma_data_v_o SHALL be 0 outside e_read; dma_data_yumi_o SHALL be 0 outside e_write.
REQ-027 Writeback beats presented in e_idle or e_read SHALL be ignored, with no yumi and no write.
REQ-028 Zero-throughput stalls of any length SHALL be tolerated in both directions; no timeout.

Reset
REQ-029 reset_n_i low SHALL force e_idle, counters to 0 and every output to 0 immediately, independent of clk_i.
REQ-030 Reset asserted mid-burst SHALL abandon the burst: remaining beats are dropped and beats already written SHALL remain until reset clears them.
REQ-031 All mem_els_p entries SHALL read 0 after reset.

Configuration
REQ-032 Macro BP_DMA_MEM_DELAY_EN, when defined, SHALL insert e_delay, which holds for exactly delay_p cycles (counter loaded at the packet yumi) and then branches to e_read or e_write.
REQ-033 Without BP_DMA_MEM_DELAY_EN, the first read beat SHALL be valid the cycle after the packet yumi, and e_delay logic and the delay_p counter SHALL be absent.

Structure
REQ-034 The shared package SHALL hold the FSM state enum and the DMA packet struct {write_not_read, addr}.
REQ-035 The storage array SHALL be a sub-module bp_dma_mem_responder_store: 1 combinational read port and 1 synchronous write port, with async-low clear.

Verification
REQ-036 Write pkt {1, 0x40}, beats 0x1..0x8 with v_i held high -> 8 consecutive yumis; mem[8..15] = 1..8; FSM back to e_idle.
REQ-037 Then read pkt {0, 0x40} with ready_and_i always 1 -> beats 0x1..0x8 on 8 consecutive cycles, the first one cycle after the yumi (macro off) or 1+delay_p=5 cycles after it (macro on).
REQ-038 Read with ready_and_i low for 3 cycles at beat 2 -> dma_data_o stable at beat 2; beat count still 8; no duplicated beat.
REQ-039 Packet at address (mem_els_p*8 + 0x40) -> same data as address 0x40 (modulo wrap).
REQ-040 reset_n_i pulsed low mid-clock at beat 4 of a read -> outputs 0 at once; next packet accepted; memory reads 0.
REQ-041 dma_pkt_v_i held high during a read burst -> dma_pkt_yumi_o is 0 until the cycle after the last beat.
